// File: rtl/axis_frame_packer.sv
// Frame-length-bounded AXI-Stream packer: accepts up to frameLen words (or until TLAST)
// through a two-entry skid buffer and reports completion, early end and abort.
module axis_frame_packer #(
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 10,
    parameter int STATE_BIT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0]    S_AXI_TKEEP,
    input  logic                       S_AXI_TVALID,
    input  logic                       S_AXI_TLAST,
    output logic                       S_AXI_TREADY,
    output logic [DATA_WIDTH-1:0]      M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]    M_AXI_TKEEP,
    output logic                       M_AXI_TVALID,
    output logic                       M_AXI_TLAST,
    input  logic                       M_AXI_TREADY,
    input  logic [LEN_WIDTH-1:0]       frameLen,
    input  logic                       frameStart,
    input  logic                       frameAbort,
    output logic                       busy,
    output logic                       finFrame,
    output logic                       earlyLast,
    output logic [STATE_BIT_WIDTH-1:0] dbg_state,
    output logic [LEN_WIDTH-1:0]       dbg_word_cnt
);
    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic [STATE_BIT_WIDTH-1:0] {
        IDLE  = STATE_BIT_WIDTH'(0),
        RUN   = STATE_BIT_WIDTH'(1),
        DRAIN = STATE_BIT_WIDTH'(2)
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  word_cnt;
    logic [LEN_WIDTH-1:0]  len_m1;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [KW-1:0]         skid_keep;
    logic                  skid_last;
    logic                  skid_valid;
    logic                  accept;
    logic                  out_free;
    logic                  in_last;
    logic                  skid_next_valid;

    assign len_m1          = len_q - LEN_WIDTH'(1);
    assign accept          = S_AXI_TVALID && S_AXI_TREADY;
    assign out_free        = !M_AXI_TVALID || M_AXI_TREADY;
    assign in_last         = S_AXI_TLAST || (word_cnt == len_m1);
    // Ready is only ever high with the skid slot empty, so a held-off accept always fits there.
    assign skid_next_valid = (skid_valid || accept) && !out_free;
    assign busy            = (state != IDLE);
    assign dbg_state       = state;
    assign dbg_word_cnt    = word_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= '0;
            word_cnt     <= '0;
            S_AXI_TREADY <= 1'b0;
            M_AXI_TDATA  <= '0;
            M_AXI_TKEEP  <= '0;
            M_AXI_TVALID <= 1'b0;
            M_AXI_TLAST  <= 1'b0;
            skid_data    <= '0;
            skid_keep    <= '0;
            skid_last    <= 1'b0;
            skid_valid   <= 1'b0;
            finFrame     <= 1'b0;
            earlyLast    <= 1'b0;
        end else begin
            finFrame <= 1'b0;
            case (state)
                IDLE: begin
                    S_AXI_TREADY <= 1'b0;
                    if (frameStart && !frameAbort && frameLen != '0) begin
                        len_q        <= frameLen;
                        word_cnt     <= '0;
                        earlyLast    <= 1'b0;
                        S_AXI_TREADY <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (frameAbort) begin
                        state        <= IDLE;
                        S_AXI_TREADY <= 1'b0;
                        M_AXI_TVALID <= 1'b0;
                        M_AXI_TLAST  <= 1'b0;
                        skid_valid   <= 1'b0;
                    end else begin
                        if (out_free) begin
                            if (skid_valid) begin
                                M_AXI_TDATA  <= skid_data;
                                M_AXI_TKEEP  <= skid_keep;
                                M_AXI_TLAST  <= skid_last;
                                M_AXI_TVALID <= 1'b1;
                            end else if (accept) begin
                                M_AXI_TDATA  <= S_AXI_TDATA;
                                M_AXI_TKEEP  <= S_AXI_TKEEP;
                                M_AXI_TLAST  <= in_last;
                                M_AXI_TVALID <= 1'b1;
                            end else begin
                                M_AXI_TVALID <= 1'b0;
                                M_AXI_TLAST  <= 1'b0;
                            end
                        end
                        if (accept && !out_free) begin
                            skid_data <= S_AXI_TDATA;
                            skid_keep <= S_AXI_TKEEP;
                            skid_last <= in_last;
                        end
                        skid_valid   <= skid_next_valid;
                        S_AXI_TREADY <= (state == RUN) && !(accept && in_last) && !skid_next_valid;
                        if (accept) begin
                            word_cnt <= word_cnt + LEN_WIDTH'(1);
                            if (in_last) begin
                                state <= DRAIN;
                                if (S_AXI_TLAST && word_cnt < len_m1)
                                    earlyLast <= 1'b1;
                            end
                        end
                        if (state == DRAIN && M_AXI_TVALID && M_AXI_TREADY && M_AXI_TLAST) begin
                            state    <= IDLE;
                            finFrame <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    S_AXI_TREADY <= 1'b0;
                    M_AXI_TVALID <= 1'b0;
                    M_AXI_TLAST  <= 1'b0;
                    skid_valid   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_packer.sv
// Self-checking bench for axis_frame_packer: table of frame scenarios plus abort and
// reset sequences; expected output words are queued on input accept and popped on output.
module tb_axis_frame_packer;
    localparam int DW = 32;
    localparam int LW = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] S_TDATA;
    logic [3:0]    S_TKEEP;
    logic          S_TVALID, S_TLAST, S_TREADY;
    logic [DW-1:0] M_TDATA;
    logic [3:0]    M_TKEEP;
    logic          M_TVALID, M_TLAST, M_TREADY;
    logic [LW-1:0] frameLen;
    logic          frameStart, frameAbort;
    logic          busy, finFrame, earlyLast;
    logic [SW-1:0] dbg_state;
    logic [LW-1:0] dbg_word_cnt;

    int total = 0;
    int bad   = 0;
    int fid   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    k;
        logic          l;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int len;
        int tl_at;
        int rmode;
        int vmode;
        int restart_at;
        int exp_out;
        int exp_early;
    } vec_t;
    vec_t tbl[9];

    axis_frame_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .STATE_BIT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_TDATA(S_TDATA), .S_AXI_TKEEP(S_TKEEP), .S_AXI_TVALID(S_TVALID),
        .S_AXI_TLAST(S_TLAST), .S_AXI_TREADY(S_TREADY),
        .M_AXI_TDATA(M_TDATA), .M_AXI_TKEEP(M_TKEEP), .M_AXI_TVALID(M_TVALID),
        .M_AXI_TLAST(M_TLAST), .M_AXI_TREADY(M_TREADY),
        .frameLen(frameLen), .frameStart(frameStart), .frameAbort(frameAbort),
        .busy(busy), .finFrame(finFrame), .earlyLast(earlyLast),
        .dbg_state(dbg_state), .dbg_word_cnt(dbg_word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int len, input int tl_at, input int rmode, input int vmode,
                             input int restart_at, input int exp_out, input int exp_early);
        int idx, got, cyc, first_s, first_m, last_m;
        bit done_in, stall_pend;
        logic [DW-1:0] stall_d, d;
        logic stall_l;
        logic [3:0] k;
        exp_t e;
        idx = 0; got = 0; cyc = 0; first_s = -1; first_m = -1; last_m = -1;
        done_in = 0; stall_pend = 0; stall_d = '0; stall_l = 1'b0;
        sb.delete();
        fid++;
        @(negedge clk);
        frameLen = LW'(len); frameStart = 1'b1; S_TVALID = 1'b0; M_TREADY = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        check("start_busy", busy, 1);
        check("start_state", dbg_state, 1);
        check("start_s_ready", S_TREADY, 1);
        while (got < exp_out && cyc < 3000) begin
            d = {fid[7:0], 8'h5A, idx[15:0]};
            k = 4'hF >> idx[1:0];
            S_TDATA  = d;
            S_TKEEP  = k;
            S_TLAST  = (idx == tl_at);
            S_TVALID = (vmode == 0) || ($urandom_range(0, 3) != 0);
            if (rmode == 0)      M_TREADY = 1'b1;
            else if (rmode == 1) M_TREADY = (cyc % 2 == 0);
            else                 M_TREADY = 1'($urandom_range(0, 1));
            if (cyc == restart_at) begin
                frameStart = 1'b1;
                frameLen   = LW'(len + 5);
            end else begin
                frameStart = 1'b0;
            end
            if (done_in && S_TVALID) begin
                check("no_accept_after_last", S_TREADY, 0);
            end else if (S_TVALID && S_TREADY) begin
                e.d = d; e.k = k; e.l = (idx == len - 1) || (idx == tl_at);
                sb.push_back(e);
                if (e.l) done_in = 1;
                if (first_s < 0) first_s = cyc;
                idx++;
            end
            if (stall_pend) begin
                check("stall_valid", M_TVALID, 1);
                check("stall_data", M_TDATA, stall_d);
                check("stall_last", M_TLAST, stall_l);
            end
            stall_pend = M_TVALID && !M_TREADY;
            stall_d = M_TDATA;
            stall_l = M_TLAST;
            if (M_TVALID && M_TREADY) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_output: got data %0h expected no word", M_TDATA);
                end else begin
                    e = sb.pop_front();
                    check("out_data", M_TDATA, e.d);
                    check("out_keep", M_TKEEP, e.k);
                    check("out_last", M_TLAST, e.l);
                end
                if (first_m < 0) first_m = cyc;
                last_m = cyc;
                got++;
            end
            check("no_fin_mid_frame", finFrame, 0);
            @(negedge clk);
            cyc++;
        end
        if (got < exp_out) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d words expected %0d", got, exp_out);
        end
        S_TVALID = 1'b0; frameStart = 1'b0; M_TREADY = 1'b1;
        check("fin_pulse", finFrame, 1);
        check("end_busy", busy, 0);
        check("end_m_valid", M_TVALID, 0);
        check("end_s_ready", S_TREADY, 0);
        check("early_last", earlyLast, exp_early);
        check("word_cnt", dbg_word_cnt, exp_out);
        check("accepted", idx, exp_out);
        check("sb_empty", sb.size(), 0);
        if (vmode == 0 && rmode == 0) begin
            check("latency", first_m, first_s + 1);
            check("throughput", last_m - first_m, exp_out - 1);
        end
        @(negedge clk);
        check("fin_one_cycle", finFrame, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc;
        tbl[0] = '{4,    -1, 0, 0, -1, 4,    0};
        tbl[1] = '{8,     2, 0, 0, -1, 3,    1};
        tbl[2] = '{6,    -1, 1, 0, -1, 6,    0};
        tbl[3] = '{1,    -1, 0, 0, -1, 1,    0};
        tbl[4] = '{5,     4, 0, 0, -1, 5,    0};
        tbl[5] = '{7,    -1, 2, 1,  2, 7,    0};
        tbl[6] = '{3,     0, 2, 0, -1, 1,    1};
        tbl[7] = '{1023, -1, 0, 0, -1, 1023, 0};
        tbl[8] = '{10,    6, 2, 1, -1, 7,    1};

        reset = 1'b1; S_TDATA = '0; S_TKEEP = '0; S_TVALID = 1'b0; S_TLAST = 1'b0;
        M_TREADY = 1'b0; frameLen = '0; frameStart = 1'b0; frameAbort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", S_TREADY, 0);
        check("rst_m_valid", M_TVALID, 0);
        check("rst_m_last", M_TLAST, 0);
        check("rst_m_data", M_TDATA, 0);
        check("rst_busy", busy, 0);
        check("rst_fin", finFrame, 0);
        check("rst_early", earlyLast, 0);
        check("rst_state", dbg_state, 0);
        check("rst_cnt", dbg_word_cnt, 0);
        reset = 1'b0;

        // zero-length start is ignored
        @(negedge clk);
        frameLen = '0; frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        check("zero_len_busy", busy, 0);
        check("zero_len_state", dbg_state, 0);
        check("zero_len_ready", S_TREADY, 0);

        for (int i = 0; i < 9; i++)
            run_frame(tbl[i].len, tbl[i].tl_at, tbl[i].rmode, tbl[i].vmode,
                      tbl[i].restart_at, tbl[i].exp_out, tbl[i].exp_early);

        // reset mid-frame with one word on the output and one in the skid slot
        @(negedge clk);
        frameLen = LW'(8); frameStart = 1'b1; M_TREADY = 1'b0; S_TVALID = 1'b0;
        @(negedge clk);
        frameStart = 1'b0; S_TVALID = 1'b1; S_TDATA = 32'hDEAD0000; S_TKEEP = 4'hF; S_TLAST = 1'b0;
        @(negedge clk);
        S_TDATA = 32'hDEAD0001;
        @(negedge clk);
        check("pre_reset_valid", M_TVALID, 1);
        check("pre_reset_state", dbg_state, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", S_TREADY, 0);
        check("midrst_m_valid", M_TVALID, 0);
        check("midrst_m_last", M_TLAST, 0);
        check("midrst_m_data", M_TDATA, 0);
        check("midrst_m_keep", M_TKEEP, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fin", finFrame, 0);
        check("midrst_early", earlyLast, 0);
        check("midrst_cnt", dbg_word_cnt, 0);
        reset = 1'b0; S_TVALID = 1'b0; M_TREADY = 1'b1;
        @(negedge clk);
        check("post_reset_no_stale", M_TVALID, 0);
        run_frame(2, -1, 0, 0, -1, 2, 0);

        // abort after five accepts while downstream is stalled
        @(negedge clk);
        frameLen = LW'(16); frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 5 && cyc < 50) begin
            S_TVALID = 1'b1; S_TDATA = 32'hAB000000 + 32'(acc); S_TKEEP = 4'hF; S_TLAST = 1'b0;
            M_TREADY = (acc < 4);
            if (S_TREADY) acc++;
            @(negedge clk);
            cyc++;
        end
        check("abort_accepts", acc, 5);
        check("abort_pre_cnt", dbg_word_cnt, 5);
        check("abort_pre_valid", M_TVALID, 1);
        check("abort_pre_ready", S_TREADY, 0);
        frameAbort = 1'b1; frameStart = 1'b1;
        @(negedge clk);
        frameAbort = 1'b0; frameStart = 1'b0; S_TVALID = 1'b0;
        check("abort_m_valid", M_TVALID, 0);
        check("abort_s_ready", S_TREADY, 0);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        check("abort_no_fin", finFrame, 0);
        @(negedge clk);
        check("abort_no_fin_late", finFrame, 0);
        check("abort_idle", busy, 0);
        M_TREADY = 1'b1;
        run_frame(2, -1, 0, 0, -1, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter LEN_WIDTH, default 10, width of the frame-length and word counters.
REQ-003 SHALL have parameter STATE_BIT_WIDTH, default 4, width of the state register and dbg_state.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports S_AXI_TDATA/TKEEP/TVALID/TLAST, input, DATA_WIDTH/DATA_WIDTH/8/1/1, upstream AXIS slave (TLAST means early end of frame).
REQ-007 SHALL have port S_AXI_TREADY, output, 1, slave ready.
REQ-008 SHALL have ports M_AXI_TDATA/TKEEP/TVALID/TLAST, output, DATA_WIDTH/DATA_WIDTH/8/1/1, downstream AXIS master feeding the streamer store interface.
REQ-009 SHALL have port M_AXI_TREADY, input, 1, master ready.
REQ-010 SHALL have port frameLen, input, LEN_WIDTH, number of words per frame, sampled on frameStart.
REQ-011 SHALL have ports frameStart and frameAbort, input, 1 each, control pulses.
REQ-012 SHALL have ports busy and finFrame, output, 1 each: busy is high when not IDLE; finFrame is a one-cycle completion pulse.
REQ-013 SHALL have port earlyLast, output, 1, high when the last completed frame ended on input TLAST before frameLen words.
REQ-014 SHALL have ports dbg_state (STATE_BIT_WIDTH) and dbg_word_cnt (LEN_WIDTH), outputs, current state and words accepted in the current frame.

Function
REQ-015 SHALL implement the states IDLE=0, RUN=1 and DRAIN=2; other encodings SHALL return to IDLE on the next cycle.
REQ-016 In IDLE, frameStart with frameLen!=0 SHALL latch frameLen, clear the word counter and earlyLast, and enter RUN next cycle; frameStart with frameLen==0 SHALL be ignored.
REQ-017 S_AXI_TREADY SHALL be a registered output, high only in RUN while the 2-entry skid buffer has a free slot; it SHALL NOT combinationally depend on S_AXI_TVALID or M_AXI_TREADY.
REQ-018 A word SHALL be accepted only on S_AXI_TVALID && S_AXI_TREADY; each accept SHALL increment the word counter by 1.
REQ-019 An accepted word SHALL be tagged last when the counter equals latched frameLen-1 or when S_AXI_TLAST=1; either event SHALL move the block to DRAIN next cycle, after which no further input is accepted.
REQ-020 earlyLast SHALL be set when the tagged-last word had S_AXI_TLAST=1 and counter < frameLen-1.
REQ-021 Latency from input accept to M_AXI_TVALID SHALL be exactly 1 cycle when the buffer is empty; sustained throughput SHALL be 1 word/cycle while M_AXI_TREADY=1.
REQ-022 M_AXI_TDATA, M_AXI_TKEEP and M_AXI_TLAST SHALL hold stable while M_AXI_TVALID=1 and M_AXI_TREADY=0; M_AXI_TVALID SHALL NOT drop without a transfer, except on abort or reset.
REQ-023 The buffer SHALL preserve word order; a word held off by downstream backpressure SHALL be stored in the skid slot without loss.
REQ-024 In DRAIN, when the tagged-last word transfers on M_AXI_TVALID && M_AXI_TREADY, finFrame SHALL pulse high for the next single cycle and the state SHALL return to IDLE.
REQ-025 frameAbort in RUN or DRAIN SHALL empty the buffer and deassert M_AXI_TVALID and S_AXI_TREADY next cycle, then enter IDLE without a finFrame pulse; frameAbort SHALL take priority over frameStart and over a simultaneous accept.
REQ-026 frameStart outside IDLE SHALL be ignored.
REQ-027 The word counter SHALL NOT wrap; frameLen up to 2^LEN_WIDTH-1 SHALL be supported.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, buffer empty, word counter 0, S_AXI_TREADY=0, M_AXI_TVALID=0, M_AXI_TLAST=0, M_AXI_TDATA=0, M_AXI_TKEEP=0, busy=0, finFrame=0, earlyLast=0.
REQ-029 Reset asserted mid-frame SHALL discard buffered words without completing any in-flight transfer.

Verification
REQ-030 frameLen=4, continuous valid, M_AXI_TREADY=1 -> 4 words out on consecutive cycles, TLAST only on word 3, finFrame one cycle after the last transfer, earlyLast=0.
REQ-031 frameLen=8, S_AXI_TLAST on word 2 -> 3 words out, TLAST on word 2, earlyLast=1, finFrame pulses.
REQ-032 frameLen=6, M_AXI_TREADY toggling 1/0 each cycle -> output order and data intact, outputs stable during stalls, no word dropped or duplicated.
REQ-033 frameLen=16, frameAbort after 5 accepts with M_AXI_TREADY=0 -> next cycle M_AXI_TVALID=0 and S_AXI_TREADY=0, IDLE, no finFrame; a new frame of length 2 then completes normally.
REQ-034 frameStart with frameLen=0 -> stays IDLE, busy=0; reset during RUN -> all outputs take their REQ-028 values on the next cycle.
